// File: rtl/ppu_arbiter.sv
// Two-requester round-robin front end for a single pipelined PPU, with an in-order tag FIFO
// that routes each PPU result back to its requester. Optional perf counters: PPU_ARB_PERF_EN.
module ppu_arbiter #(
   parameter int WORD    = 32,
   parameter int OP_SIZE = 3,
   parameter int DEPTH   = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic [1:0]           req_valid_i,
   output logic [1:0]           req_ready_o,
   input  logic [2*WORD-1:0]    req_op1_i,
   input  logic [2*WORD-1:0]    req_op2_i,
   input  logic [2*OP_SIZE-1:0] req_op_i,
   output logic                 ppu_valid_o,
   output logic [WORD-1:0]      ppu_op1_o,
   output logic [WORD-1:0]      ppu_op2_o,
   output logic [OP_SIZE-1:0]   ppu_op_o,
   input  logic [WORD-1:0]      ppu_result_i,
   input  logic                 ppu_valid_i,
   output logic [1:0]           rsp_valid_o,
   output logic [WORD-1:0]      rsp_data_o,
   output logic                 err_o
`ifdef PPU_ARB_PERF_EN
   ,
   output logic [31:0]          perf_issue0_o,
   output logic [31:0]          perf_issue1_o,
   output logic [31:0]          perf_full_o
`endif
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [CNT_W-1:0]   count_q;
   logic [PTR_W-1:0]   wr_ptr_q;
   logic [PTR_W-1:0]   rd_ptr_q;
   logic               tag_mem [DEPTH];
   logic               prio_q;

   logic               full;
   logic               empty;
   logic               accept;
   logic               gnt_id;
   logic               pop;
   logic               head_id;
   logic [WORD-1:0]    sel_op1;
   logic [WORD-1:0]    sel_op2;
   logic [OP_SIZE-1:0] sel_op;

   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);

   // prio_q names the requester that wins when both are valid.
   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      gnt_id      = prio_q;
      accept      = 1'b0;
      req_ready_o = 2'b00;
      if (rst_ni && !full) begin
         case (req_valid_i)
            2'b01:   gnt_id = 1'b0;
            2'b10:   gnt_id = 1'b1;
            2'b11:   gnt_id = prio_q;
            default: gnt_id = prio_q;
         endcase
         if (req_valid_i != 2'b00) begin
            accept              = 1'b1;
            req_ready_o[gnt_id] = 1'b1;
         end
      end
   end

   assign sel_op1 = gnt_id ? req_op1_i[2*WORD-1:WORD]       : req_op1_i[WORD-1:0];
   assign sel_op2 = gnt_id ? req_op2_i[2*WORD-1:WORD]       : req_op2_i[WORD-1:0];
   assign sel_op  = gnt_id ? req_op_i[2*OP_SIZE-1:OP_SIZE]  : req_op_i[OP_SIZE-1:0];

   assign head_id     = tag_mem[rd_ptr_q];
   assign pop         = rst_ni && ppu_valid_i && !empty;
   assign rsp_valid_o = pop ? (head_id ? 2'b10 : 2'b01) : 2'b00;
   assign rsp_data_o  = ppu_result_i;

   // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         count_q     <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         prio_q      <= 1'b0;
         ppu_valid_o <= 1'b0;
         ppu_op1_o   <= '0;
         ppu_op2_o   <= '0;
         ppu_op_o    <= '0;
         err_o       <= 1'b0;
      end else begin
         ppu_valid_o <= accept;
         if (accept) begin
            ppu_op1_o <= sel_op1;
            ppu_op2_o <= sel_op2;
            ppu_op_o  <= sel_op;
            wr_ptr_q  <= wr_ptr_q + PTR_W'(1);
            prio_q    <= ~gnt_id;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         case ({accept, pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
         if (ppu_valid_i && empty) begin
            err_o <= 1'b1;
         end
      end
   end

   // NOTE: tag storage is not reset; the pointers and count define which entries are live.
   always_ff @(posedge clk_i) begin
      if (accept) begin
         tag_mem[wr_ptr_q] <= gnt_id;
      end
   end

`ifdef PPU_ARB_PERF_EN
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         perf_issue0_o <= '0;
         perf_issue1_o <= '0;
         perf_full_o   <= '0;
      end else begin
         if (accept && !gnt_id) perf_issue0_o <= perf_issue0_o + 32'd1;
         if (accept &&  gnt_id) perf_issue1_o <= perf_issue1_o + 32'd1;
         if (full && (req_valid_i != 2'b00)) perf_full_o <= perf_full_o + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_ppu_arbiter.sv
// Directed self-checking bench for ppu_arbiter (DEPTH=8, WORD=32, OP_SIZE=3).
module tb_ppu_arbiter;

   localparam int WORD    = 32;
   localparam int OP_SIZE = 3;
   localparam int DEPTH   = 8;

   logic                 clk_i = 1'b0;
   logic                 rst_ni;
   logic [1:0]           req_valid_i;
   logic [1:0]           req_ready_o;
   logic [2*WORD-1:0]    req_op1_i;
   logic [2*WORD-1:0]    req_op2_i;
   logic [2*OP_SIZE-1:0] req_op_i;
   logic                 ppu_valid_o;
   logic [WORD-1:0]      ppu_op1_o;
   logic [WORD-1:0]      ppu_op2_o;
   logic [OP_SIZE-1:0]   ppu_op_o;
   logic [WORD-1:0]      ppu_result_i;
   logic                 ppu_valid_i;
   logic [1:0]           rsp_valid_o;
   logic [WORD-1:0]      rsp_data_o;
   logic                 err_o;
`ifdef PPU_ARB_PERF_EN
   logic [31:0]          perf_issue0_o;
   logic [31:0]          perf_issue1_o;
   logic [31:0]          perf_full_o;
`endif

   int checks   = 0;
   int failures = 0;

   ppu_arbiter #(.WORD(WORD), .OP_SIZE(OP_SIZE), .DEPTH(DEPTH)) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .req_valid_i  (req_valid_i),
      .req_ready_o  (req_ready_o),
      .req_op1_i    (req_op1_i),
      .req_op2_i    (req_op2_i),
      .req_op_i     (req_op_i),
      .ppu_valid_o  (ppu_valid_o),
      .ppu_op1_o    (ppu_op1_o),
      .ppu_op2_o    (ppu_op2_o),
      .ppu_op_o     (ppu_op_o),
      .ppu_result_i (ppu_result_i),
      .ppu_valid_i  (ppu_valid_i),
      .rsp_valid_o  (rsp_valid_o),
      .rsp_data_o   (rsp_data_o),
      .err_o        (err_o)
`ifdef PPU_ARB_PERF_EN
      ,
      .perf_issue0_o(perf_issue0_o),
      .perf_issue1_o(perf_issue1_o),
      .perf_full_o  (perf_full_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Inputs change 1 time unit after a rising edge; combinational outputs are sampled at the falling edge.
   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic mid();
      #4;
   endtask

   task automatic do_reset();
      rst_ni       = 1'b0;
      req_valid_i  = 2'b11;
      ppu_valid_i  = 1'b1;
      ppu_result_i = 32'hDEAD_BEEF;
      mid();
      check("reset_ready", 64'(req_ready_o), 64'(2'b00));
      check("reset_rsp",   64'(rsp_valid_o), 64'(2'b00));
      step();
      step();
      rst_ni      = 1'b1;
      req_valid_i = 2'b00;
      ppu_valid_i = 1'b0;
      check("post_reset_ppu_valid", 64'(ppu_valid_o), 64'(1'b0));
      check("post_reset_op1",       64'(ppu_op1_o),   64'(0));
      check("post_reset_op",        64'(ppu_op_o),    64'(0));
      check("post_reset_err",       64'(err_o),       64'(1'b0));
   endtask

   initial begin
      int accepts;
      logic [1:0] exp_seq [4];
      logic [1:0] last_ready;
      exp_seq = '{2'b01, 2'b10, 2'b01, 2'b10};

      rst_ni       = 1'b0;
      req_valid_i  = 2'b00;
      ppu_valid_i  = 1'b0;
      ppu_result_i = '0;
      req_op1_i    = '0;
      req_op2_i    = '0;
      req_op_i     = '0;
      step();

      // Single accept from requester 0, issued one cycle later, then its result routed back.
      do_reset();
      req_valid_i = 2'b01;
      req_op1_i   = {32'h0, 32'h4000_0000};
      req_op2_i   = {32'h0, 32'h4000_0000};
      req_op_i    = 6'b000_000;
      mid();
      check("single_ready", 64'(req_ready_o), 64'(2'b01));
      step();
      req_valid_i = 2'b00;
      check("single_issue_valid", 64'(ppu_valid_o), 64'(1'b1));
      check("single_issue_op1",   64'(ppu_op1_o),   64'h4000_0000);
      check("single_issue_op2",   64'(ppu_op2_o),   64'h4000_0000);
      check("single_issue_op",    64'(ppu_op_o),    64'(0));
      ppu_valid_i  = 1'b1;
      ppu_result_i = 32'h8000_0000;
      mid();
      check("single_rsp_valid", 64'(rsp_valid_o), 64'(2'b01));
      check("single_rsp_data",  64'(rsp_data_o),  64'h8000_0000);
      step();
      ppu_valid_i = 1'b0;
      check("single_idle_valid", 64'(ppu_valid_o), 64'(1'b0));
      check("single_hold_op1",   64'(ppu_op1_o),   64'h4000_0000);
      check("single_no_err",     64'(err_o),       64'(1'b0));

      // Both requesters valid: alternating grants, then in-order result routing.
      do_reset();
      req_op1_i   = {32'h0000_0101, 32'h0000_0100};
      req_op2_i   = {32'h0000_0201, 32'h0000_0200};
      req_op_i    = {3'd2, 3'd1};
      req_valid_i = 2'b11;
      for (int i = 0; i < 4; i++) begin
         mid();
         check($sformatf("rr_ready_%0d", i), 64'(req_ready_o), 64'(exp_seq[i]));
         step();
         check($sformatf("rr_issue_op1_%0d", i), 64'(ppu_op1_o), 64'(32'h100 + (i % 2)));
         check($sformatf("rr_issue_op_%0d", i),  64'(ppu_op_o),  64'((i % 2) + 1));
      end
      req_valid_i = 2'b00;
      for (int i = 0; i < 4; i++) begin
         ppu_valid_i  = 1'b1;
         ppu_result_i = 32'hA000_0000 + 32'(i);
         mid();
         check($sformatf("rr_rsp_valid_%0d", i), 64'(rsp_valid_o), 64'(exp_seq[i]));
         check($sformatf("rr_rsp_data_%0d", i),  64'(rsp_data_o),  64'(32'hA000_0000 + i));
         step();
      end
      ppu_valid_i = 1'b0;
`ifdef PPU_ARB_PERF_EN
      check("perf_issue0", 64'(perf_issue0_o), 64'(2));
      check("perf_issue1", 64'(perf_issue1_o), 64'(2));
      check("perf_full",   64'(perf_full_o),   64'(0));
`endif
      check("rr_no_err", 64'(err_o), 64'(1'b0));

      // Fill to DEPTH, same-cycle pop does not free a slot, then drain across the pointer wrap.
      do_reset();
      req_valid_i = 2'b01;
      accepts     = 0;
      last_ready  = 2'b11;
      for (int i = 0; i < 10; i++) begin
         mid();
         if (req_ready_o == 2'b01) accepts++;
         last_ready = req_ready_o;
         step();
      end
      check("fill_accepts",    64'(accepts),    64'(8));
      check("fill_ready_full", 64'(last_ready), 64'(2'b00));
      ppu_valid_i  = 1'b1;
      ppu_result_i = 32'h0000_0055;
      mid();
      check("full_pop_rsp",   64'(rsp_valid_o), 64'(2'b01));
      check("full_pop_ready", 64'(req_ready_o), 64'(2'b00));
      step();
      ppu_valid_i = 1'b0;
      mid();
      check("after_pop_ready", 64'(req_ready_o), 64'(2'b01));
      step();
      mid();
      check("refull_ready", 64'(req_ready_o), 64'(2'b00));
      step();
      req_valid_i = 2'b00;
      for (int i = 0; i < DEPTH; i++) begin
         ppu_valid_i = 1'b1;
         mid();
         check($sformatf("drain_rsp_%0d", i), 64'(rsp_valid_o), 64'(2'b01));
         step();
      end
      ppu_valid_i = 1'b0;
      req_valid_i = 2'b10;
      mid();
      check("drain_no_err",    64'(err_o),       64'(1'b0));
      check("drain_ready_req1", 64'(req_ready_o), 64'(2'b10));
      step();
      req_valid_i = 2'b00;

      // Unsolicited result raises a sticky error until reset.
      do_reset();
      ppu_valid_i  = 1'b1;
      ppu_result_i = 32'h1234_5678;
      mid();
      check("spurious_rsp", 64'(rsp_valid_o), 64'(2'b00));
      step();
      ppu_valid_i = 1'b0;
      check("spurious_err", 64'(err_o), 64'(1'b1));
      step();
      step();
      check("spurious_err_sticky", 64'(err_o), 64'(1'b1));
      do_reset();

      // Reset mid-operation discards tags; a late result then flags an error.
      req_valid_i = 2'b11;
      step();
      step();
      req_valid_i = 2'b00;
      do_reset();
      ppu_valid_i = 1'b1;
      mid();
      check("late_rsp", 64'(rsp_valid_o), 64'(2'b00));
      step();
      ppu_valid_i = 1'b0;
      check("late_err", 64'(err_o), 64'(1'b1));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ppu_arbiter.md
PPU_ARBITER -- requirements
Module: ppu_arbiter

Interface
REQ-001 SHALL have parameter WORD, default 32, meaning operand/result width.
REQ-002 SHALL have parameter OP_SIZE, default 3, meaning PPU opcode width.
REQ-003 SHALL have parameter DEPTH, default 8, meaning the maximum number of in-flight PPU ops and the tag FIFO depth (power of 2, ≥2).
REQ-004 clk_i  in  1  sole clock; all state updates on rising edge.
REQ-005 rst_ni  in  1  reset, synchronous and active-low.
REQ-006 req_valid_i  in  2  per-requester request valid.
REQ-007 req_ready_o  out  2  per-requester accept.
REQ-008 req_op1_i  in  2*WORD  operand1 (requester r at bits [r*WORD +: WORD]).
REQ-009 req_op2_i  in  2*WORD  operand2, same packing.
REQ-010 req_op_i  in  2*OP_SIZE  opcode, same packing.
REQ-011 ppu_valid_o, ppu_op1_o, ppu_op2_o, ppu_op_o  out  1/WORD/WORD/OP_SIZE  issue to the PPU in_valid_i/operand1_i/operand2_i/op_i.
REQ-012 ppu_result_i, ppu_valid_i  in  WORD/1  PPU result_o/out_valid_o.
REQ-013 rsp_valid_o  out  2  one-hot result-valid per requester.
REQ-014 rsp_data_o  out  WORD  result, shared by both requesters.
REQ-015 err_o  out  1  sticky error flag.

Function
REQ-016 Accept (handshake) for requester r SHALL occur when req_valid_i[r] & req_ready_o[r] are both high; at most one req_ready_o bit SHALL be high per cycle.
REQ-017 req_ready_o SHALL be all-zero when the in-flight count equals DEPTH; a same-cycle pop SHALL NOT free the slot for that cycle.
REQ-018 Arbitration SHALL be round-robin: with one valid requester, grant it; with both valid, grant the requester not granted at the last accept; the pointer SHALL update only on accept.
REQ-019 req_ready_o SHALL be combinational from req_valid_i, the pointer and count; ready SHALL NOT depend on ppu_valid_i.
REQ-020 On accept, the ppu_* outputs SHALL be registered: ppu_valid_o=1 with the accepted operands/opcode exactly 1 cycle later, else ppu_valid_o=0 and data held.
REQ-021 On accept, the requester ID SHALL be pushed into an in-order tag FIFO; count increments.
REQ-022 On ppu_valid_i with non-empty FIFO: pop head ID h, and the same cycle drive rsp_valid_o[h]=1 and rsp_data_o=ppu_result_i (combinational, 0 latency); count decrements.
REQ-023 Push and pop in the same cycle SHALL leave count unchanged; FIFO pointers SHALL wrap modulo DEPTH.
REQ-024 ppu_valid_i while FIFO empty SHALL set err_o=1 (sticky until reset); rsp_valid_o SHALL stay 0.
REQ-025 Responses SHALL have no backpressure; the requester must sink rsp_valid_o.

Reset
REQ-026 With rst_ni=0 at a clock edge: count=0, FIFO empty, pointer favours requester 0, ppu_valid_o=0, ppu_op1_o/ppu_op2_o/ppu_op_o=0, err_o=0.
REQ-027 During reset, req_ready_o and rsp_valid_o SHALL be 0.
REQ-028 Reset mid-operation SHALL discard all in-flight tags; late PPU results after reset SHALL raise err_o.

Configuration
REQ-029 With macro PPU_ARB_PERF_EN defined, the block SHALL add outputs perf_issue0_o and perf_issue1_o (32 bits each, accept counts per requester, wrap at 2^32, reset 0) and perf_full_o (32 bits, counts cycles with any req_valid_i high while count==DEPTH).
REQ-030 Without PPU_ARB_PERF_EN, those ports and counters SHALL not exist; the remaining behaviour SHALL be identical.

Verification
REQ-031 Reset, then req_valid_i=2'b01 with op1=0x40000000, op2=0x40000000, op=0 -> req_ready_o=01 that cycle; next cycle ppu_valid_o=1 with same values.
REQ-032 Both requesters valid for 4 cycles -> grants 0,1,0,1; PPU results returned in order -> rsp_valid_o=01,10,01,10.
REQ-033 DEPTH=8, only req0 valid and no results for 10 cycles -> 8 accepts, then req_ready_o=00; one ppu_valid_i -> rsp_valid_o=01, ready returns the next cycle.
REQ-034 Count at 8, ppu_valid_i and req_valid_i=01 in the same cycle -> no accept that cycle; accept next cycle; count remains ≤8.
REQ-035 After reset, ppu_valid_i=1 with ppu_result_i=0x12345678 -> rsp_valid_o=00, err_o=1 and holds until rst_ni=0.
REQ-036 With PPU_ARB_PERF_EN, run REQ-032 -> perf_issue0_o=2, perf_issue1_o=2, perf_full_o=0.
